// File: rtl/ripple_counter_4bit.sv
// Free-running WIDTH-bit up-counter built from toggle stages with a rippled carry.
// Ports: Q (count out), clk (rising-edge clock), clear (sync active-high reset).
module ripple_counter_4bit #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] Q,
  input  logic             clk,
  input  logic             clear
);

  // toggle[i] is high when stages 0..i-1 are all 1.
  // Stage 0 always toggles, so the chain is seeded with 1.
  logic [WIDTH-1:0] toggle;

  always_comb begin
    toggle    = '0;
    toggle[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & Q[i-1];
    end
  end

  // clear wins over counting; otherwise each stage flips on its carry.
  always_ff @(posedge clk) begin
    if (clear) begin
      Q <= '0;
    end else begin
      Q <= Q ^ toggle;
    end
  end

endmodule

// File: tb/tb_ripple_counter_4bit.sv
// Directed self-checking bench for ripple_counter_4bit.
// Covers reset, counting, wrap, mid-count clear, clear priority and WIDTH=8.
module tb_ripple_counter_4bit;

  logic       clk;
  logic       clear4;
  logic       clear8;
  logic [3:0] q4;
  logic [7:0] q8;

  int checks;
  int errors;

  ripple_counter_4bit #(.WIDTH(4)) dut4 (
    .Q     (q4),
    .clk   (clk),
    .clear (clear4)
  );

  ripple_counter_4bit #(.WIDTH(8)) dut8 (
    .Q     (q8),
    .clk   (clk),
    .clear (clear8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset4();
    clear4 = 1'b1;
    step();
    clear4 = 1'b0;
  endtask

  task automatic test_reset();
    clear4 = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      step();
      checks++;
      if (q4 !== 4'b0000) begin
        errors++;
        $display("FAIL reset edge%0d: got %b want 0000", e, q4);
      end
    end
    clear4 = 1'b0;
  endtask

  task automatic test_count();
    logic [3:0] held;
    reset4();
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (q4 !== 4'(e)) begin
        errors++;
        $display("FAIL count edge%0d: got %0d want %0d", e, q4, e);
      end
      held = q4;
      @(negedge clk);
      #1;
      checks++;
      if (q4 !== held) begin
        errors++;
        $display("FAIL negedge edge%0d: got %0d want %0d", e, q4, held);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    reset4();
    for (int e = 1; e <= 17; e++) begin
      step();
      exp = 4'(e % 16);
      checks++;
      if (q4 !== exp) begin
        errors++;
        $display("FAIL wrap edge%0d: got %0d want %0d", e, q4, exp);
      end
    end
  endtask

  task automatic test_mid_clear();
    reset4();
    repeat (7) step();
    checks++;
    if (q4 !== 4'b0111) begin
      errors++;
      $display("FAIL mid_pre: got %b want 0111", q4);
    end
    clear4 = 1'b1;
    step();
    checks++;
    if (q4 !== 4'b0000) begin
      errors++;
      $display("FAIL mid_clear: got %b want 0000", q4);
    end
    clear4 = 1'b0;
    step();
    checks++;
    if (q4 !== 4'b0001) begin
      errors++;
      $display("FAIL mid_resume: got %b want 0001", q4);
    end
  endtask

  task automatic test_priority();
    reset4();
    repeat (15) step();
    checks++;
    if (q4 !== 4'b1111) begin
      errors++;
      $display("FAIL prio_pre: got %b want 1111", q4);
    end
    clear4 = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (q4 !== 4'b0000) begin
        errors++;
        $display("FAIL prio_hold edge%0d: got %b want 0000", e, q4);
      end
    end
    clear4 = 1'b0;
    step();
    checks++;
    if (q4 !== 4'b0001) begin
      errors++;
      $display("FAIL prio_resume: got %b want 0001", q4);
    end
  endtask

  task automatic test_width8();
    logic [7:0] exp;
    clear8 = 1'b1;
    step();
    checks++;
    if (q8 !== 8'h00) begin
      errors++;
      $display("FAIL w8_reset: got %h want 00", q8);
    end
    clear8 = 1'b0;
    for (int e = 1; e <= 256; e++) begin
      step();
      exp = 8'(e % 256);
      checks++;
      if (q8 !== exp) begin
        errors++;
        $display("FAIL w8 edge%0d: got %h want %h", e, q8, exp);
      end
    end
    checks++;
    if (q8 !== 8'h00) begin
      errors++;
      $display("FAIL w8_wrap: got %h want 00", q8);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear4 = 1'b1;
    clear8 = 1'b1;
    #1;
    test_reset();
    test_count();
    test_wrap();
    test_mid_clear();
    test_priority();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
